// File: rtl/hit_arbiter.sv
// Per-frame collision arbiter: gathers pixel-overlap events during a frame and
// resolves them into updated ball velocities once the frame closes.
module hit_arbiter #(
    parameter int NUM_BALLS = 2,
    parameter int VEL_W     = 11,
    parameter int COOLDOWN  = 8
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       startOfFrame,
    input  logic [NUM_BALLS-1:0]       ballDR,
    input  logic                       bordersDR,
    input  logic                       borderIsVertical,
    input  logic                       holesDR,
    input  logic [2:0]                 holeNumber,
    input  logic [NUM_BALLS*VEL_W-1:0] ballVelX,
    input  logic [NUM_BALLS*VEL_W-1:0] ballVelY,
    output logic [NUM_BALLS*VEL_W-1:0] ballVelXOut,
    output logic [NUM_BALLS*VEL_W-1:0] ballVelYOut,
    output logic [NUM_BALLS-1:0]       collisionOccurred,
    output logic [NUM_BALLS-1:0]       holeHit,
    output logic [3*NUM_BALLS-1:0]     holeNum,
    output logic                       busy
);

    localparam int NUM_PAIRS = NUM_BALLS * (NUM_BALLS - 1) / 2;
    localparam logic signed [VEL_W-1:0] VMIN = {1'b1, {(VEL_W-1){1'b0}}};
    localparam logic signed [VEL_W-1:0] VMAX = {1'b0, {(VEL_W-1){1'b1}}};

    typedef enum logic [1:0] {COLLECT, EVAL, PUBLISH} state_t;

    state_t                  state;
    logic [NUM_BALLS-1:0]    vFlag, hFlag, holeFlag;
    logic [NUM_PAIRS-1:0]    pairFlag, pairNow;
    logic [2:0]              holeLatch [NUM_BALLS];
    logic [7:0]              cooldown  [NUM_BALLS];

    logic signed [VEL_W-1:0] inX   [NUM_BALLS];
    logic signed [VEL_W-1:0] inY   [NUM_BALLS];
    logic signed [VEL_W-1:0] nextX [NUM_BALLS];
    logic signed [VEL_W-1:0] nextY [NUM_BALLS];
    logic [NUM_BALLS-1:0]    pairHit, commit;
    logic                    pairFound;

    // Pairs (i<j) are packed row by row into a flat vector.
    function automatic int pairIdx(input int i, input int j);
        return i * NUM_BALLS - (i * (i + 1)) / 2 + (j - i - 1);
    endfunction

    // Negating the most negative value would wrap, so clamp it to the max.
    function automatic logic signed [VEL_W-1:0] satNeg(input logic signed [VEL_W-1:0] v);
        if (v == VMIN)
            return VMAX;
        return -v;
    endfunction

    always_comb begin
        pairNow = '0;
        for (int i = 0; i < NUM_BALLS; i++) begin
            inX[i] = ballVelX[i*VEL_W +: VEL_W];
            inY[i] = ballVelY[i*VEL_W +: VEL_W];
            for (int j = i + 1; j < NUM_BALLS; j++)
                pairNow[pairIdx(i, j)] = ballDR[i] & ballDR[j];
        end
    end

    // Only the first eligible pair (lowest i, then lowest j) wins the frame.
    always_comb begin
        pairFound = 1'b0;
        pairHit   = '0;
        commit    = '0;
        for (int i = 0; i < NUM_BALLS; i++) begin
            nextX[i] = inX[i];
            nextY[i] = inY[i];
        end
        for (int i = 0; i < NUM_BALLS; i++) begin
            for (int j = i + 1; j < NUM_BALLS; j++) begin
                if (!pairFound && pairFlag[pairIdx(i, j)] && !holeFlag[i] && !holeFlag[j] &&
                    cooldown[i] == 8'd0 && cooldown[j] == 8'd0) begin
                    pairFound  = 1'b1;
                    pairHit[i] = 1'b1;
                    pairHit[j] = 1'b1;
                    nextX[i]   = inX[j];
                    nextY[i]   = inY[j];
                    nextX[j]   = inX[i];
                    nextY[j]   = inY[i];
                end
            end
        end
        for (int i = 0; i < NUM_BALLS; i++) begin
            if (holeFlag[i]) begin
                nextX[i] = '0;
                nextY[i] = '0;
            end else if (pairHit[i]) begin
                commit[i] = 1'b1;
            end else if ((vFlag[i] || hFlag[i]) && cooldown[i] == 8'd0) begin
                commit[i] = 1'b1;
                if (vFlag[i])
                    nextX[i] = satNeg(inX[i]);
                if (hFlag[i])
                    nextY[i] = satNeg(inY[i]);
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state             <= COLLECT;
            vFlag             <= '0;
            hFlag             <= '0;
            holeFlag          <= '0;
            pairFlag          <= '0;
            ballVelXOut       <= '0;
            ballVelYOut       <= '0;
            collisionOccurred <= '0;
            holeHit           <= '0;
            holeNum           <= '0;
            busy              <= 1'b0;
            for (int i = 0; i < NUM_BALLS; i++) begin
                holeLatch[i] <= '0;
                cooldown[i]  <= '0;
            end
        end else begin
            case (state)
                COLLECT: begin
                    for (int i = 0; i < NUM_BALLS; i++) begin
                        if (ballDR[i] && bordersDR && borderIsVertical)
                            vFlag[i] <= 1'b1;
                        if (ballDR[i] && bordersDR && !borderIsVertical)
                            hFlag[i] <= 1'b1;
                        if (ballDR[i] && holesDR) begin
                            holeFlag[i] <= 1'b1;
                            if (!holeFlag[i])
                                holeLatch[i] <= holeNumber;
                        end
                    end
                    pairFlag <= pairFlag | pairNow;
                    if (startOfFrame) begin
                        state <= EVAL;
                        busy  <= 1'b1;
                    end
                end
                EVAL: begin
                    for (int i = 0; i < NUM_BALLS; i++) begin
                        ballVelXOut[i*VEL_W +: VEL_W] <= nextX[i];
                        ballVelYOut[i*VEL_W +: VEL_W] <= nextY[i];
                        if (holeFlag[i])
                            holeNum[i*3 +: 3] <= holeLatch[i];
                        if (commit[i])
                            cooldown[i] <= 8'(COOLDOWN);
                        else if (cooldown[i] != 8'd0)
                            cooldown[i] <= cooldown[i] - 8'd1;
                    end
                    collisionOccurred <= commit;
                    holeHit           <= holeFlag;
                    state             <= PUBLISH;
                end
                PUBLISH: begin
                    collisionOccurred <= '0;
                    holeHit           <= '0;
                    vFlag             <= '0;
                    hFlag             <= '0;
                    holeFlag          <= '0;
                    pairFlag          <= '0;
                    for (int i = 0; i < NUM_BALLS; i++)
                        holeLatch[i] <= '0;
                    busy              <= 1'b0;
                    state             <= COLLECT;
                end
                default: state <= COLLECT;
            endcase
        end
    end

endmodule

// File: tb/tb_hit_arbiter.sv
// Directed bench for hit_arbiter with two balls: borders, pairs, holes,
// cooldown, saturation and reset during evaluation.
module tb_hit_arbiter;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        startOfFrame = 1'b0;
    logic [1:0]  ballDR = '0;
    logic        bordersDR = 1'b0;
    logic        borderIsVertical = 1'b0;
    logic        holesDR = 1'b0;
    logic [2:0]  holeNumber = '0;
    logic [21:0] ballVelX = '0;
    logic [21:0] ballVelY = '0;
    logic [21:0] ballVelXOut, ballVelYOut;
    logic [1:0]  collisionOccurred, holeHit;
    logic [5:0]  holeNum;
    logic        busy;

    int assertCount = 0;
    int failCount   = 0;

    logic signed [10:0] outX0, outY0, outX1, outY1;
    assign outX0 = ballVelXOut[10:0];
    assign outY0 = ballVelYOut[10:0];
    assign outX1 = ballVelXOut[21:11];
    assign outY1 = ballVelYOut[21:11];

    hit_arbiter dut (
        .clk(clk), .reset(reset), .startOfFrame(startOfFrame), .ballDR(ballDR),
        .bordersDR(bordersDR), .borderIsVertical(borderIsVertical), .holesDR(holesDR),
        .holeNumber(holeNumber), .ballVelX(ballVelX), .ballVelY(ballVelY),
        .ballVelXOut(ballVelXOut), .ballVelYOut(ballVelYOut),
        .collisionOccurred(collisionOccurred), .holeHit(holeHit),
        .holeNum(holeNum), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input int observed, input int expected);
        assertCount++;
        if (observed !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got %0d, expected %0d", tag, observed, expected);
        end
    endtask

    task automatic setVel(input int b, input int x, input int y);
        ballVelX[b*11 +: 11] = 11'(x);
        ballVelY[b*11 +: 11] = 11'(y);
    endtask

    // One COLLECT cycle with the given draw-request pattern.
    task automatic applyStimulus(input logic [1:0] dr, input logic border, input logic vert,
                                 input logic hole, input logic [2:0] hn);
        ballDR = dr; bordersDR = border; borderIsVertical = vert;
        holesDR = hole; holeNumber = hn;
        tick();
        ballDR = '0; bordersDR = 1'b0; borderIsVertical = 1'b0;
        holesDR = 1'b0; holeNumber = '0;
    endtask

    // Leaves the bench one step into the PUBLISH cycle.
    task automatic closeFrame();
        startOfFrame = 1'b1;
        tick();
        startOfFrame = 1'b0;
        tick();
    endtask

    task automatic doReset();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        ballVelX = '0;
        ballVelY = '0;
        tick();
    endtask

    initial begin
        tick();
        checkOutput("reset busy", int'(busy), 0);
        checkOutput("reset coll", int'(collisionOccurred), 0);
        checkOutput("reset holeHit", int'(holeHit), 0);
        checkOutput("reset holeNum", int'(holeNum), 0);
        checkOutput("reset velX", int'(ballVelXOut), 0);
        doReset();

        // Vertical border on ball 0
        setVel(0, 5, -3); setVel(1, 7, 2);
        applyStimulus(2'b01, 1'b1, 1'b1, 1'b0, 3'd0);
        startOfFrame = 1'b1;
        tick();
        startOfFrame = 1'b0;
        checkOutput("eval busy", int'(busy), 1);
        tick();
        checkOutput("border X0", int'(outX0), -5);
        checkOutput("border Y0", int'(outY0), -3);
        checkOutput("border X1", int'(outX1), 7);
        checkOutput("border Y1", int'(outY1), 2);
        checkOutput("border coll", int'(collisionOccurred), 1);
        checkOutput("publish busy", int'(busy), 1);
        tick();
        checkOutput("border coll drop", int'(collisionOccurred), 0);
        checkOutput("border hold X0", int'(outX0), -5);
        checkOutput("idle busy", int'(busy), 0);

        // Ball-ball swap
        doReset();
        setVel(0, 4, 0); setVel(1, -2, 1);
        repeat (3) applyStimulus(2'b11, 1'b0, 1'b0, 1'b0, 3'd0);
        closeFrame();
        checkOutput("pair X0", int'(outX0), -2);
        checkOutput("pair Y0", int'(outY0), 1);
        checkOutput("pair X1", int'(outX1), 4);
        checkOutput("pair Y1", int'(outY1), 0);
        checkOutput("pair coll", int'(collisionOccurred), 3);
        tick();

        // Cooldown: frame N commits, N+1..N+8 ignored, N+9 commits
        doReset();
        setVel(0, 3, 4);
        applyStimulus(2'b01, 1'b1, 1'b1, 1'b0, 3'd0);
        closeFrame();
        checkOutput("cool N coll", int'(collisionOccurred), 1);
        checkOutput("cool N X0", int'(outX0), -3);
        tick();
        for (int f = 1; f <= 8; f++) begin
            applyStimulus(2'b01, 1'b1, 1'b1, 1'b0, 3'd0);
            closeFrame();
            checkOutput($sformatf("cool N+%0d coll", f), int'(collisionOccurred), 0);
            tick();
        end
        checkOutput("cool passthru X0", int'(outX0), 3);
        applyStimulus(2'b01, 1'b1, 1'b1, 1'b0, 3'd0);
        closeFrame();
        checkOutput("cool N+9 coll", int'(collisionOccurred), 1);
        checkOutput("cool N+9 X0", int'(outX0), -3);
        tick();

        // Hole beats border; first hole number is kept
        doReset();
        setVel(1, 6, -2); setVel(0, 1, 1);
        applyStimulus(2'b10, 1'b0, 1'b0, 1'b1, 3'd3);
        applyStimulus(2'b10, 1'b0, 1'b0, 1'b1, 3'd5);
        applyStimulus(2'b10, 1'b1, 1'b1, 1'b0, 3'd0);
        closeFrame();
        checkOutput("hole holeHit", int'(holeHit), 2);
        checkOutput("hole holeNum", int'(holeNum), 24);
        checkOutput("hole X1", int'(outX1), 0);
        checkOutput("hole Y1", int'(outY1), 0);
        checkOutput("hole coll", int'(collisionOccurred), 0);
        checkOutput("hole X0", int'(outX0), 1);
        tick();
        checkOutput("hole pulse drop", int'(holeHit), 0);

        // Saturating negation, both borders
        doReset();
        setVel(0, -1024, 7);
        applyStimulus(2'b01, 1'b1, 1'b1, 1'b0, 3'd0);
        applyStimulus(2'b01, 1'b1, 1'b0, 1'b0, 3'd0);
        closeFrame();
        checkOutput("sat X0", int'(outX0), 1023);
        checkOutput("sat Y0", int'(outY0), -7);
        tick();

        // Activity in the startOfFrame cycle counts; activity in EVAL does not
        doReset();
        setVel(0, 9, 1); setVel(1, 2, 5);
        ballDR = 2'b01; bordersDR = 1'b1; borderIsVertical = 1'b1; startOfFrame = 1'b1;
        tick();
        ballDR = 2'b10; borderIsVertical = 1'b0; startOfFrame = 1'b0;
        tick();
        ballDR = '0; bordersDR = 1'b0;
        checkOutput("sof X0", int'(outX0), -9);
        checkOutput("sof coll", int'(collisionOccurred), 1);
        tick();
        closeFrame();
        checkOutput("eval discard coll", int'(collisionOccurred), 0);
        checkOutput("eval discard Y1", int'(outY1), 5);
        tick();

        // Reset during EVAL
        doReset();
        setVel(0, 5, -3);
        applyStimulus(2'b01, 1'b1, 1'b1, 1'b0, 3'd0);
        closeFrame();
        tick();
        applyStimulus(2'b01, 1'b1, 1'b1, 1'b0, 3'd0);
        startOfFrame = 1'b1;
        tick();
        startOfFrame = 1'b0;
        reset = 1'b1;
        #1;
        checkOutput("rst eval X0", int'(outX0), 0);
        checkOutput("rst eval busy", int'(busy), 0);
        tick();
        reset = 1'b0;
        tick();
        checkOutput("rst after coll", int'(collisionOccurred), 0);
        tick();
        checkOutput("rst after coll2", int'(collisionOccurred), 0);
        checkOutput("rst after busy", int'(busy), 0);
        applyStimulus(2'b01, 1'b1, 1'b1, 1'b0, 3'd0);
        closeFrame();
        checkOutput("rst resume X0", int'(outX0), -5);
        checkOutput("rst resume coll", int'(collisionOccurred), 1);
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule

// File: doc/hit_arbiter.md
HIT_ARBITER -- requirements
Module: hit_arbiter

Interface
REQ-001 SHALL have parameter NUM_BALLS, default 2, number of balls arbitrated (2..8).
REQ-002 SHALL have parameter VEL_W, default 11, signed velocity width.
REQ-003 SHALL have parameter COOLDOWN, default 8, frames a ball ignores border/ball events after a committed collision (1..255).
REQ-004 SHALL have clk  in  1  single clock; reset  in  1  asynchronous active-high reset.
REQ-005 SHALL have startOfFrame  in  1  one-cycle pulse closing the current frame.
REQ-006 SHALL have ballDR  in  NUM_BALLS  per-ball draw request of current pixel.
REQ-007 SHALL have bordersDR  in  1, borderIsVertical  in  1 (1 = left/right border pixel), holesDR  in  1, holeNumber  in  3.
REQ-008 SHALL have ballVelX, ballVelY  in  NUM_BALLS*VEL_W  flattened signed velocities, ball i at bits [i*VEL_W +: VEL_W].
REQ-009 SHALL have ballVelXOut, ballVelYOut  out  NUM_BALLS*VEL_W  registered updated velocities.
REQ-010 SHALL have collisionOccurred  out  NUM_BALLS  one-cycle pulse per ball with new velocity.
REQ-011 SHALL have holeHit  out  NUM_BALLS  one-cycle pulse; holeNum  out  3*NUM_BALLS  hole index per ball.
REQ-012 SHALL have busy  out  1  high in EVAL and PUBLISH.

Function
REQ-013 SHALL implement FSM COLLECT -> EVAL -> PUBLISH -> COLLECT; COLLECT->EVAL on startOfFrame; EVAL and PUBLISH last exactly one cycle each.
REQ-014 SHALL in COLLECT set sticky flags per ball: vBorder[i] on ballDR[i]&bordersDR&borderIsVertical; hBorder[i] on ballDR[i]&bordersDR&!borderIsVertical; hole[i] on ballDR[i]&holesDR.
REQ-015 SHALL latch holeNumber on the first hole event per ball per frame; later hole events in the same frame do not overwrite it.
REQ-016 SHALL in COLLECT set sticky pair flag pair[i][j] (i<j) when ballDR[i]&ballDR[j] in the same cycle.
REQ-017 SHALL count DR activity in the startOfFrame cycle itself toward the closing frame.
REQ-018 SHALL in EVAL sample input velocities and resolve per ball with priority hole > ball-ball > border.
REQ-019 SHALL for hole[i] assert holeHit[i], drive holeNum[i], set ball velocity output to 0, regardless of cooldown.
REQ-020 SHALL select exactly one ball pair per frame: lowest i, then lowest j, among flagged pairs where neither ball has a hole event nor nonzero cooldown; other pairs dropped.
REQ-021 SHALL for the selected pair output swapped velocity vectors (ball i gets ball j's X and Y, and vice versa).
REQ-022 SHALL for border with zero cooldown and no higher-priority event negate X if vBorder, negate Y if hBorder, both if both.
REQ-023 SHALL saturate negation of the most negative value (-2^(VEL_W-1)) to +2^(VEL_W-1)-1.
REQ-024 SHALL for balls with no committed event output the sampled input velocity unchanged with collisionOccurred=0.
REQ-025 SHALL in PUBLISH pulse collisionOccurred[i] for balls with a committed ball-ball or border event, and holeHit[i] for hole events; velocity outputs hold until next PUBLISH.
REQ-026 SHALL load cooldown[i]=COOLDOWN on a committed ball-ball or border event, otherwise decrement nonzero cooldown by 1 in EVAL.
REQ-027 SHALL clear all sticky flags in PUBLISH; events during EVAL/PUBLISH are discarded.
REQ-028 SHALL ignore startOfFrame while in EVAL or PUBLISH.

Reset
REQ-029 SHALL on reset asynchronously force state COLLECT, all flags, cooldowns, velocity outputs, holeNum, collisionOccurred, holeHit and busy to 0.
REQ-030 SHALL on reset mid-EVAL/PUBLISH emit no pulses and resume in COLLECT after release.

Verification
REQ-031 SHALL verify: ball0 vel (5,-3), DR0&bordersDR&borderIsVertical for 1 cycle, startOfFrame -> 2 cycles later ballVelXOut0=-5, Y=-3, collisionOccurred=01 for 1 cycle.
REQ-032 SHALL verify: ball0 (4,0), ball1 (-2,1), overlap 3 cycles, startOfFrame -> out0=(-2,1), out1=(4,0), collisionOccurred=11.
REQ-033 SHALL verify: border hit in frame N then again in frames N+1..N+8 -> only frame N commits; frame N+9 hit commits again.
REQ-034 SHALL verify: ball1 hits hole 3 then hole 5 and border in one frame -> holeHit=10, holeNum1=3, out1=(0,0), collisionOccurred1=0.
REQ-035 SHALL verify: ball0 vel X=-1024, vertical border hit -> ballVelXOut0=+1023.
REQ-036 SHALL verify: reset asserted during EVAL -> all outputs 0, no pulse, next frame processes normally.
